// File: rtl/spike_net_pkg.sv
// Shared types and helpers for the spiking pixel classifier.
// Weights are WIDTH+1 bits: MSB selects inhibitory, low WIDTH bits are the magnitude.
package spike_net_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_HEIGHT      = 7;
  localparam int DEF_STIM_PERIOD = 4;
  localparam int DEF_THRESHOLD   = 16;

  typedef logic [DEF_WIDTH:0] weight_t;

  localparam weight_t EXC_60 = 9'd60;
  localparam weight_t INH_4  = 9'd260;

  localparam logic [DEF_HEIGHT*(DEF_WIDTH+1)-1:0] DEF_WEIGHTS =
    {EXC_60, EXC_60, EXC_60, INH_4, INH_4, INH_4, INH_4};

  function automatic logic is_inhib(input logic [31:0] w, input int width);
    return w[width];
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] w, input int width);
    return w & ((32'd1 << width) - 32'd1);
  endfunction

  // Counter width for a modulus; a modulus of 1 still needs one bit.
  function automatic int cnt_bits(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/spike_pixel_network_divider.sv
// Event-counting spike divider: fires on the event that completes a run of mag events.
// A magnitude of 0 never fires and keeps the counter parked at zero.
module spike_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] mag,
  input  logic             ev,
  output logic             fire
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             mag_zero;

  always_comb begin
    mag_zero = (mag == '0);
    fire     = ev && !mag_zero && (cnt_q == mag - ONE);
    cnt_d    = cnt_q;
    if (ev) begin
      cnt_d = (fire || mag_zero) ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spike_pixel_network.sv
// Spiking classifier: per-pixel dividers gated by a periodic stimulus feed an
// integrate-and-fire output neuron. All slow timing is done with clock enables.
module spike_pixel_network
  import spike_net_pkg::*;
#(
  parameter int                              WIDTH       = DEF_WIDTH,
  parameter int                              HEIGHT      = DEF_HEIGHT,
  parameter logic [HEIGHT*(WIDTH+1)-1:0]     WEIGHTS     = DEF_WEIGHTS,
  parameter int                              STIM_PERIOD = DEF_STIM_PERIOD,
  parameter int                              THRESHOLD   = DEF_THRESHOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HEIGHT-1:0] pixels,
  output logic              neuron_out
);

  localparam int TICK_W = cnt_bits(HEIGHT);
  localparam int STIM_W = cnt_bits(STIM_PERIOD);
  localparam int ACC_W  = $clog2(THRESHOLD + HEIGHT) + 1;
  localparam int POP_W  = $clog2(HEIGHT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HEIGHT - 1);
  localparam logic [STIM_W-1:0] STIM_LAST = STIM_W'(STIM_PERIOD - 1);
  localparam logic [ACC_W:0]    THRESH_X  = (ACC_W + 1)'(THRESHOLD);
  localparam logic [ACC_W:0]    ACC_MAX   = {1'b0, {ACC_W{1'b1}}};

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [STIM_W-1:0] stim_cnt_q, stim_cnt_d;
  logic              tick, stim;
  logic [HEIGHT-1:0] fire, po;
  logic [POP_W-1:0]  pop;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              neuron_out_q, neuron_out_d;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    stim       = tick && (stim_cnt_q == STIM_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    stim_cnt_d = stim_cnt_q;
    if (tick) begin
      stim_cnt_d = (stim_cnt_q == STIM_LAST) ? '0 : stim_cnt_q + STIM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      stim_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      stim_cnt_q <= stim_cnt_d;
    end
  end

  for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_pixel
    localparam logic [WIDTH:0]   W_I   = WEIGHTS[gi*(WIDTH+1) +: (WIDTH+1)];
    localparam logic [WIDTH-1:0] MAG_I = WIDTH'(magnitude(32'(W_I), WIDTH));

    logic ev;
    assign ev = stim & pixels[gi];

    spike_divider #(
      .WIDTH (WIDTH)
    ) u_div (
      .clk  (clk),
      .rst  (rst),
      .mag  (MAG_I),
      .ev   (ev),
      .fire (fire[gi])
    );

    if (is_inhib(32'(W_I), WIDTH)) begin : g_inh
      // Passes every stimulus except the one on which its own divider fires.
      assign po[gi] = stim & ~fire[gi];
    end else begin : g_exc
      logic pend_q, pend_d;

      // A fire on the releasing tick re-arms the latch for the following tick.
      always_comb begin
        pend_d = fire[gi] | (pend_q & ~tick);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pend_q <= 1'b0;
        end else begin
          pend_q <= pend_d;
        end
      end

      assign po[gi] = pend_q & tick;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < HEIGHT; i++) begin
      pop = pop + POP_W'(po[i]);
    end
    sum = {1'b0, acc_q} + (ACC_W + 1)'(pop);
    if (sum >= THRESH_X) begin
      neuron_out_d = 1'b1;
      acc_d        = '0;
    end else begin
      neuron_out_d = 1'b0;
      acc_d        = (sum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      neuron_out_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      neuron_out_q <= neuron_out_d;
    end
  end

  assign neuron_out = neuron_out_q;

endmodule

// File: tb/tb_spike_pixel_network.sv
// Scoreboard bench: expected spike/stimulus edge numbers (counted from reset release)
// are queued up front and a negedge monitor pops them as the DUTs present events.
module tb_spike_pixel_network;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] pixels;
  logic [6:0] pix_all = 7'h7F;
  logic       neuron_out, neuron_out_w1, neuron_out_z;

  int  cyc;
  logic rst_s;
  logic flush, check_aux;
  int  n_vec  = 0;
  int  n_miss = 0;

  int q_spk[$];
  int q_stim[$];
  int q_w1[$];

  always #5 clk = ~clk;

  spike_pixel_network dut (
    .clk        (clk),
    .rst        (rst),
    .pixels     (pixels),
    .neuron_out (neuron_out)
  );

  spike_pixel_network #(
    .WEIGHTS   ({7{9'd1}}),
    .THRESHOLD (7)
  ) dut_w1 (
    .clk        (clk),
    .rst        (rst),
    .pixels     (pix_all),
    .neuron_out (neuron_out_w1)
  );

  spike_pixel_network #(
    .WEIGHTS   (63'd0)
  ) dut_z (
    .clk        (clk),
    .rst        (rst),
    .pixels     (pix_all),
    .neuron_out (neuron_out_z)
  );

  // cyc = number of clock edges since reset release
  always @(posedge clk) begin
    rst_s <= rst;
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int e;
    if (rst_s === 1'b1) begin
      n_vec = n_vec + 3;
      if (neuron_out !== 1'b0) begin
        n_miss++; $display("FAIL reset_out_dut: got %b want 0", neuron_out);
      end
      if (neuron_out_w1 !== 1'b0) begin
        n_miss++; $display("FAIL reset_out_w1: got %b want 0", neuron_out_w1);
      end
      if (neuron_out_z !== 1'b0) begin
        n_miss++; $display("FAIL reset_out_z: got %b want 0", neuron_out_z);
      end
    end else begin
      if (neuron_out !== 1'b0) begin
        n_vec++;
        if (q_spk.size() == 0) begin
          n_miss++; $display("FAIL spike_dut: got neuron_out=%b at edge %0d, want 0 (no spike due)", neuron_out, cyc);
        end else begin
          e = q_spk.pop_front();
          if (e != cyc || neuron_out !== 1'b1) begin
            n_miss++; $display("FAIL spike_dut: got neuron_out=%b at edge %0d, want spike at edge %0d", neuron_out, cyc, e);
          end else $display("spike_dut ok at edge %0d", cyc);
        end
      end else if (q_spk.size() > 0 && q_spk[0] < cyc) begin
        n_vec++; n_miss++;
        e = q_spk.pop_front();
        $display("FAIL spike_dut_missing: got no spike by edge %0d, want spike at edge %0d", cyc, e);
      end

      if (dut.stim !== 1'b0) begin
        n_vec++;
        if (q_stim.size() == 0) begin
          n_miss++; $display("FAIL stim_dut: got stim=%b at edge %0d, want 0", dut.stim, cyc + 1);
        end else begin
          e = q_stim.pop_front();
          if (e != cyc + 1 || dut.stim !== 1'b1) begin
            n_miss++; $display("FAIL stim_dut: got stim=%b at edge %0d, want stim at edge %0d", dut.stim, cyc + 1, e);
          end
        end
      end else if (q_stim.size() > 0 && q_stim[0] < cyc + 1) begin
        n_vec++; n_miss++;
        e = q_stim.pop_front();
        $display("FAIL stim_dut_missing: got no stim by edge %0d, want stim at edge %0d", cyc + 1, e);
      end

      if (check_aux) begin
        if (neuron_out_w1 !== 1'b0) begin
          n_vec++;
          if (q_w1.size() == 0) begin
            n_miss++; $display("FAIL spike_w1: got neuron_out=%b at edge %0d, want 0", neuron_out_w1, cyc);
          end else begin
            e = q_w1.pop_front();
            if (e != cyc || neuron_out_w1 !== 1'b1) begin
              n_miss++; $display("FAIL spike_w1: got neuron_out=%b at edge %0d, want spike at edge %0d", neuron_out_w1, cyc, e);
            end
          end
        end else if (q_w1.size() > 0 && q_w1[0] < cyc) begin
          n_vec++; n_miss++;
          e = q_w1.pop_front();
          $display("FAIL spike_w1_missing: got no spike by edge %0d, want spike at edge %0d", cyc, e);
        end
        if (neuron_out_z !== 1'b0) begin
          n_vec++; n_miss++;
          $display("FAIL spike_zero_weight: got neuron_out=%b at edge %0d, want 0", neuron_out_z, cyc);
        end
      end
    end

    if (flush) begin
      n_vec = n_vec + 3;
      if (q_spk.size() != 0) begin
        n_miss++; $display("FAIL leftover_spike_dut: got %0d unmatched, want 0", q_spk.size());
      end
      if (q_stim.size() != 0) begin
        n_miss++; $display("FAIL leftover_stim_dut: got %0d unmatched, want 0", q_stim.size());
      end
      if (q_w1.size() != 0) begin
        n_miss++; $display("FAIL leftover_spike_w1: got %0d unmatched, want 0", q_w1.size());
      end
      q_spk.delete(); q_stim.delete(); q_w1.delete();
    end
  end

  task automatic run_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic end_scenario();
    @(posedge clk);
    flush = 1'b1;
    check_aux = 1'b0;
    @(posedge clk);
    flush = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pixels = 7'd0; flush = 1'b0; check_aux = 1'b1;

    // Scenario 1: pixels=0. Inhibitory pixels pass every stim (+4), spike every 112 edges.
    // All-weight-1 instance spikes one tick after each stim; zero-weight instance never spikes.
    for (int k = 1; k <= 25; k++)  q_spk.push_back(112 * k);
    for (int k = 1; k <= 100; k++) q_stim.push_back(28 * k);
    for (int k = 0; k < 100; k++)  q_w1.push_back(35 + 28 * k);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    run_until(2810);
    end_scenario();
    $display("scenario pixels=0: done");

    // Scenario 2: inhibitory dividers fire on every 4th stim and contribute nothing then.
    pixels = 7'b0001111;
    do_reset(5);
    q_spk.push_back(140); q_spk.push_back(280); q_spk.push_back(420);
    for (int k = 1; k <= 15; k++) q_stim.push_back(28 * k);
    run_until(430);
    end_scenario();
    $display("scenario pixels=0001111: done");

    // Scenario 3: one-cycle reset at acc=12 restarts the whole schedule.
    pixels = 7'd0;
    do_reset(5);
    for (int k = 1; k <= 3; k++) q_stim.push_back(28 * k);
    run_until(90);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_spk.push_back(112);
    for (int k = 1; k <= 4; k++) q_stim.push_back(28 * k);
    run_until(120);
    end_scenario();
    $display("scenario mid-reset: done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
